hazard_scheduler: RTL and testbench
===================================

Name: hazard_scheduler

Overview:
Scheduler stage 1, the receiving end of the check stage bundle (CHECK_*). Keeps a per-register scoreboard of in-flight destination writes. Issues hazard-free instructions into a registered SCHEDULE_* bundle for register read. Asserts STALL back upstream on RAW or scoreboard-saturation hazards, and releases scoreboard entries on writeback.

Parameters:
CNT_W, 2, width of each per-register pending-write counter; MAX = 2^CNT_W-1 in-flight writes per register

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
FLUSH  in  1  pipeline flush
MEM_WAIT  in  1  memory wait; freeze issue register
CHECK_ACCEPT  in  1  check-stage slot holds a valid instruction
CHECK_PC  in  32  instruction PC
CHECK_OPCODE  in  17  packed opcode
CHECK_RD  in  5  destination register; 0 = no write
CHECK_RS1  in  5  source register 1
CHECK_RS2  in  5  source register 2
CHECK_CSR  in  12  CSR address
CHECK_IMM  in  32  immediate
WB_VALID  in  1  writeback retiring this cycle
WB_RD  in  5  writeback destination
STALL  out  1  upstream must hold check-stage contents (combinational)
SCHEDULE_VALID  out  1  issue register holds a valid instruction
SCHEDULE_PC  out  32  issued PC
SCHEDULE_OPCODE  out  17  issued opcode
SCHEDULE_RD  out  5  issued rd
SCHEDULE_RS1  out  5  issued rs1
SCHEDULE_RS2  out  5  issued rs2
SCHEDULE_CSR  out  12  issued CSR
SCHEDULE_IMM  out  32  issued immediate

Behaviour:
- Scoreboard: cnt[1..31], each CNT_W bits. cnt[0] is not stored and reads as 0.
- hazard = CHECK_ACCEPT && ((RS1!=0 && cnt[RS1]!=0) || (RS2!=0 && cnt[RS2]!=0) || (RD!=0 && cnt[RD]==MAX)).
- Hazard evaluates on registered counts only. There is no same-cycle writeback bypass: a WB in cycle N clears the hazard in cycle N+1.
- STALL = hazard && !FLUSH && !RST. It is a pure function of current inputs and state.
- issue = CHECK_ACCEPT && !hazard && !MEM_WAIT && !FLUSH.
- Priority, highest first: RST > FLUSH > MEM_WAIT > normal.
- RST: all cnt=0. SCHEDULE_VALID=0 and all SCHEDULE_* fields=0.
- FLUSH:
  - Issue register cleared (valid 0, fields 0).
  - All cnt cleared to 0, because downstream is flushed in the same cycle.
  - WB_VALID in the flush cycle is ignored.
- MEM_WAIT:
  - Issue register holds its value.
  - No increment.
  - Writeback decrements still apply.
- Normal cycle:
  - If issue: issue register loads all CHECK_* fields and SCHEDULE_VALID=1.
  - Otherwise: SCHEDULE_VALID=0 and fields=0 (bubble).
  - Latency is 1 cycle from accepted CHECK_* to SCHEDULE_*.
- Counter update per register r:
  - inc = issue && CHECK_RD==r.
  - dec = WB_VALID && WB_RD==r && cnt[r]!=0.
  - inc&&dec: unchanged. inc only: +1. dec only: -1.
  - WB to a register with cnt 0, or to x0: ignored, no underflow.
  - The saturation check guarantees inc never overflows.
- An instruction reading and writing the same register (e.g. rd=rs1=5) issues when cnt[5]==0 and then sets cnt[5]=1.
- CHECK_ACCEPT=0: no hazard, no issue, bubble, STALL=0.

Test Plan:
- Reset, then idle: SCHEDULE_VALID=0, STALL=0, all outputs 0.
- RAW hazard:
  - Issue rd=5 at cycle 0; next instruction rs1=5 → STALL=1 and bubbles.
  - WB_VALID, WB_RD=5 at cycle k → STALL=0 at k+1, issue visible at k+2.
- x0 and saturation:
  - rd=0/rs1=0 streams never stall and never change the scoreboard.
  - Four back-to-back writes to x7 with no WB → the 4th stalls (cnt[7]=3). One WB releases it.
- Simultaneous events:
  - Issue rd=9 while WB_RD=9 with cnt[9]=1 → cnt stays 1.
  - WB_RD=12 with cnt[12]=0 → cnt stays 0.
- FLUSH while stalled on rs2=3 (cnt[3]=2): next cycle SCHEDULE_VALID=0, cnt all 0, STALL=0, the same instruction then issues.
- MEM_WAIT held 3 cycles with a valid issued instruction (PC=0x100): outputs hold PC=0x100. A WB during the wait decrements its counter. The next instruction issues on the cycle MEM_WAIT drops.

Source files
------------

// File: rtl/hazard_scheduler.sv
// Scheduler stage 1: tracks in-flight destination writes per register and
// issues hazard-free check-stage instructions into a registered schedule bundle.
module hazard_scheduler #(
  parameter int CNT_W = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        MEM_WAIT,
  input  logic        CHECK_ACCEPT,
  input  logic [31:0] CHECK_PC,
  input  logic [16:0] CHECK_OPCODE,
  input  logic [4:0]  CHECK_RD,
  input  logic [4:0]  CHECK_RS1,
  input  logic [4:0]  CHECK_RS2,
  input  logic [11:0] CHECK_CSR,
  input  logic [31:0] CHECK_IMM,
  input  logic        WB_VALID,
  input  logic [4:0]  WB_RD,
  output logic        STALL,
  output logic        SCHEDULE_VALID,
  output logic [31:0] SCHEDULE_PC,
  output logic [16:0] SCHEDULE_OPCODE,
  output logic [4:0]  SCHEDULE_RD,
  output logic [4:0]  SCHEDULE_RS1,
  output logic [4:0]  SCHEDULE_RS2,
  output logic [11:0] SCHEDULE_CSR,
  output logic [31:0] SCHEDULE_IMM
);

  localparam logic [CNT_W-1:0] MAX = '1;

  // Handshake: CHECK_ACCEPT qualifies the CHECK_* bundle. While STALL is high the
  // upstream stage holds the bundle unchanged; the bundle is consumed on any cycle
  // where issue is true, and appears on SCHEDULE_* one cycle later.

  // x0 is never tracked; it always reads as zero pending writes.
  logic [CNT_W-1:0] cnt [1:31];

  logic [CNT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt;
  logic             hazard;
  logic             issue;
  logic [31:1]      inc_vec;
  logic [31:1]      dec_vec;

  always_comb begin
    rs1_cnt = '0;
    rs2_cnt = '0;
    rd_cnt  = '0;
    if (CHECK_RS1 != 5'd0) rs1_cnt = cnt[CHECK_RS1];
    if (CHECK_RS2 != 5'd0) rs2_cnt = cnt[CHECK_RS2];
    if (CHECK_RD  != 5'd0) rd_cnt  = cnt[CHECK_RD];
  end

  // Hazard looks only at registered counts: a writeback frees the source next cycle.
  always_comb begin
    hazard = CHECK_ACCEPT &&
             (((CHECK_RS1 != 5'd0) && (rs1_cnt != '0)) ||
              ((CHECK_RS2 != 5'd0) && (rs2_cnt != '0)) ||
              ((CHECK_RD  != 5'd0) && (rd_cnt  == MAX)));
    STALL  = hazard && !FLUSH && !RST;
    issue  = CHECK_ACCEPT && !hazard && !MEM_WAIT && !FLUSH;
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < 32; r++) begin
      inc_vec[r] = issue && (CHECK_RD == 5'(r));
      dec_vec[r] = WB_VALID && (WB_RD == 5'(r)) && (cnt[r] != '0);
    end
  end

  always_ff @(posedge CLK) begin
    for (int r = 1; r < 32; r++) begin
      if (RST || FLUSH) begin
        cnt[r] <= '0;
      end else begin
        case ({inc_vec[r], dec_vec[r]})
          2'b10:   cnt[r] <= cnt[r] + CNT_W'(1);
          2'b01:   cnt[r] <= cnt[r] - CNT_W'(1);
          default: cnt[r] <= cnt[r];
        endcase
      end
    end
  end

  // Issue register: cleared on reset/flush, frozen on memory wait, else load or bubble.
  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      SCHEDULE_VALID  <= 1'b0;
      SCHEDULE_PC     <= '0;
      SCHEDULE_OPCODE <= '0;
      SCHEDULE_RD     <= '0;
      SCHEDULE_RS1    <= '0;
      SCHEDULE_RS2    <= '0;
      SCHEDULE_CSR    <= '0;
      SCHEDULE_IMM    <= '0;
    end else if (!MEM_WAIT) begin
      if (issue) begin
        SCHEDULE_VALID  <= 1'b1;
        SCHEDULE_PC     <= CHECK_PC;
        SCHEDULE_OPCODE <= CHECK_OPCODE;
        SCHEDULE_RD     <= CHECK_RD;
        SCHEDULE_RS1    <= CHECK_RS1;
        SCHEDULE_RS2    <= CHECK_RS2;
        SCHEDULE_CSR    <= CHECK_CSR;
        SCHEDULE_IMM    <= CHECK_IMM;
      end else begin
        SCHEDULE_VALID  <= 1'b0;
        SCHEDULE_PC     <= '0;
        SCHEDULE_OPCODE <= '0;
        SCHEDULE_RD     <= '0;
        SCHEDULE_RS1    <= '0;
        SCHEDULE_RS2    <= '0;
        SCHEDULE_CSR    <= '0;
        SCHEDULE_IMM    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: expected issue bundles are queued when
// driven and popped when the schedule register shows them.
module tb_hazard_scheduler;

  localparam int W = 108;

  logic        CLK, RST, FLUSH, MEM_WAIT;
  logic        CHECK_ACCEPT;
  logic [31:0] CHECK_PC;
  logic [16:0] CHECK_OPCODE;
  logic [4:0]  CHECK_RD, CHECK_RS1, CHECK_RS2;
  logic [11:0] CHECK_CSR;
  logic [31:0] CHECK_IMM;
  logic        WB_VALID;
  logic [4:0]  WB_RD;
  logic        STALL, SCHEDULE_VALID;
  logic [31:0] SCHEDULE_PC;
  logic [16:0] SCHEDULE_OPCODE;
  logic [4:0]  SCHEDULE_RD, SCHEDULE_RS1, SCHEDULE_RS2;
  logic [11:0] SCHEDULE_CSR;
  logic [31:0] SCHEDULE_IMM;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  logic [W-1:0] obs;
  int n_tests;
  int n_fails;

  hazard_scheduler #(.CNT_W(2)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .MEM_WAIT(MEM_WAIT),
    .CHECK_ACCEPT(CHECK_ACCEPT), .CHECK_PC(CHECK_PC), .CHECK_OPCODE(CHECK_OPCODE),
    .CHECK_RD(CHECK_RD), .CHECK_RS1(CHECK_RS1), .CHECK_RS2(CHECK_RS2),
    .CHECK_CSR(CHECK_CSR), .CHECK_IMM(CHECK_IMM),
    .WB_VALID(WB_VALID), .WB_RD(WB_RD), .STALL(STALL),
    .SCHEDULE_VALID(SCHEDULE_VALID), .SCHEDULE_PC(SCHEDULE_PC),
    .SCHEDULE_OPCODE(SCHEDULE_OPCODE), .SCHEDULE_RD(SCHEDULE_RD),
    .SCHEDULE_RS1(SCHEDULE_RS1), .SCHEDULE_RS2(SCHEDULE_RS2),
    .SCHEDULE_CSR(SCHEDULE_CSR), .SCHEDULE_IMM(SCHEDULE_IMM)
  );

  // Clock / watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic drive(input logic [31:0] pc, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    CHECK_ACCEPT = 1'b1;
    CHECK_PC     = pc;
    CHECK_OPCODE = 17'($urandom_range(0, 17'h1ffff));
    CHECK_RD     = rd;
    CHECK_RS1    = rs1;
    CHECK_RS2    = rs2;
    CHECK_CSR    = 12'($urandom_range(0, 4095));
    CHECK_IMM    = $urandom;
  endtask

  task automatic idle();
    CHECK_ACCEPT = 1'b0;
    CHECK_PC     = '0;
    CHECK_OPCODE = '0;
    CHECK_RD     = '0;
    CHECK_RS1    = '0;
    CHECK_RS2    = '0;
    CHECK_CSR    = '0;
    CHECK_IMM    = '0;
  endtask

  task automatic wb(input logic [4:0] rd);
    WB_VALID = 1'b1;
    WB_RD    = rd;
  endtask

  // One cycle: check STALL, queue expected issue, clock, check schedule register.
  // mode 0 = bubble expected, 1 = new issue expected, 2 = previous issue held.
  task automatic step(input int mode, input logic exp_stall, input string tag);
    logic [W-1:0] exp;
    #1;
    n_tests++;
    assert (STALL === exp_stall) else begin
      n_fails++;
      $error("FAIL %s stall: observed %0b expected %0b", tag, STALL, exp_stall);
    end
    if (mode == 1)
      exp_q.push_back({CHECK_PC, CHECK_OPCODE, CHECK_RD, CHECK_RS1, CHECK_RS2, CHECK_CSR, CHECK_IMM});
    @(posedge CLK);
    #1;
    WB_VALID = 1'b0;
    WB_RD    = '0;
    FLUSH    = 1'b0;
    obs = {SCHEDULE_PC, SCHEDULE_OPCODE, SCHEDULE_RD, SCHEDULE_RS1, SCHEDULE_RS2,
           SCHEDULE_CSR, SCHEDULE_IMM};
    if (mode == 1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fails++;
        $error("FAIL %s queue: observed empty expected entry", tag);
        exp = '0;
      end else begin
        exp = exp_q.pop_front();
      end
      last_exp = exp;
    end else if (mode == 2) begin
      exp = last_exp;
    end else begin
      exp = '0;
    end
    n_tests++;
    assert (SCHEDULE_VALID === (mode != 0)) else begin
      n_fails++;
      $error("FAIL %s valid: observed %0b expected %0b", tag, SCHEDULE_VALID, mode != 0);
    end
    n_tests++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s bundle: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fails  = 0;
    last_exp = '0;
    RST = 1'b1; FLUSH = 1'b0; MEM_WAIT = 1'b0;
    WB_VALID = 1'b0; WB_RD = '0;
    idle();
    @(posedge CLK);

    // Reset and idle
    step(0, 1'b0, "reset");
    RST = 1'b0;
    step(0, 1'b0, "idle");

    // RAW on x5, released by writeback (no same-cycle bypass)
    drive(32'h10, 5'd5, 5'd1, 5'd2);  step(1, 1'b0, "issue_rd5");
    drive(32'h14, 5'd6, 5'd5, 5'd0);  step(0, 1'b1, "raw_stall");
    step(0, 1'b1, "raw_stall2");
    wb(5'd5);                          step(0, 1'b1, "raw_wb_cycle");
    step(1, 1'b0, "raw_release");

    // x0 stream never stalls and never touches the scoreboard
    for (int i = 0; i < 3; i++) begin
      drive(32'h20 + 32'(i * 4), 5'd0, 5'd0, 5'd0);
      if (i == 1) wb(5'd0);
      step(1, 1'b0, "x0_stream");
    end
    idle(); wb(5'd6);                  step(0, 1'b0, "wb6");

    // Saturation on x7
    for (int i = 0; i < 3; i++) begin
      drive(32'h40 + 32'(i * 4), 5'd7, 5'd0, 5'd0);
      step(1, 1'b0, "x7_fill");
    end
    drive(32'h4c, 5'd7, 5'd0, 5'd0);  step(0, 1'b1, "sat_stall");
    wb(5'd7);                          step(0, 1'b1, "sat_wb");
    step(1, 1'b0, "sat_release");
    idle();
    for (int i = 0; i < 3; i++) begin
      wb(5'd7); step(0, 1'b0, "x7_drain");
    end
    drive(32'h50, 5'd0, 5'd7, 5'd0);  step(1, 1'b0, "x7_clear");

    // Simultaneous increment and writeback on x9
    drive(32'h60, 5'd9, 5'd0, 5'd0);  step(1, 1'b0, "issue_rd9");
    drive(32'h64, 5'd9, 5'd0, 5'd0);  wb(5'd9); step(1, 1'b0, "inc_dec9");
    drive(32'h68, 5'd0, 5'd9, 5'd0);  step(0, 1'b1, "cnt9_one");
    wb(5'd9);                          step(0, 1'b1, "cnt9_wb");
    step(1, 1'b0, "cnt9_zero");

    // Writeback to an idle register does not underflow
    idle(); wb(5'd12);                 step(0, 1'b0, "wb12_idle");
    drive(32'h70, 5'd0, 5'd12, 5'd0); step(1, 1'b0, "wb12_no_underflow");

    // FLUSH while stalled on rs2=3 with two writes pending
    drive(32'h80, 5'd3, 5'd0, 5'd0);  step(1, 1'b0, "issue_rd3_a");
    drive(32'h84, 5'd3, 5'd0, 5'd0);  step(1, 1'b0, "issue_rd3_b");
    drive(32'h200, 5'd0, 5'd0, 5'd3); step(0, 1'b1, "rs2_stall");
    FLUSH = 1'b1; wb(5'd3);            step(0, 1'b0, "flush_stalled");
    step(1, 1'b0, "post_flush_issue");
    drive(32'h204, 5'd10, 5'd0, 5'd0); FLUSH = 1'b1; step(0, 1'b0, "flush_blocks");
    drive(32'h208, 5'd0, 5'd10, 5'd0); step(1, 1'b0, "flush_no_inc");

    // MEM_WAIT holds the issue register while writebacks still retire
    drive(32'h100, 5'd14, 5'd0, 5'd0); step(1, 1'b0, "issue_pc100");
    drive(32'h104, 5'd15, 5'd14, 5'd0);
    MEM_WAIT = 1'b1;                    step(2, 1'b1, "mw1");
    wb(5'd14);                          step(2, 1'b1, "mw2");
    step(2, 1'b0, "mw3");
    MEM_WAIT = 1'b0;                    step(1, 1'b0, "mw_release");
    drive(32'h108, 5'd0, 5'd15, 5'd0); step(0, 1'b1, "cnt15_one");
    wb(5'd15);                          step(0, 1'b1, "cnt15_wb");
    step(1, 1'b0, "no_inc_in_wait");
    idle();                             step(0, 1'b0, "final_idle");

    n_tests++;
    assert (exp_q.size() == 0) else begin
      n_fails++;
      $error("FAIL queue_drain: observed %0d entries expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
